// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundles the PC-source select, retire, instruction-memory
// handshake and program-counter signals between the fetch sequencer and
// the control unit / datapath / instruction memory.
//   master : the fetch sequencer (drives imem_req, PC, PCPlus4, PCPlus8,
//            fetch_valid, redirect_cnt, align_err)
//   slave  : the environment (drives PCS, Result, instr_done, imem_ready)
interface pc_fetch_if #(
  parameter int unsigned CNT_W = 16
);
  logic              PCS;
  logic [31:0]       Result;
  logic              instr_done;
  logic              imem_ready;
  logic              imem_req;
  logic [31:0]       PC;
  logic [31:0]       PCPlus4;
  logic [31:0]       PCPlus8;
  logic              fetch_valid;
  logic [CNT_W-1:0]  redirect_cnt;
  logic              align_err;

  modport master (
    input  PCS, Result, instr_done, imem_ready,
    output imem_req, PC, PCPlus4, PCPlus8, fetch_valid, redirect_cnt, align_err
  );

  modport slave (
    output PCS, Result, instr_done, imem_ready,
    input  imem_req, PC, PCPlus4, PCPlus8, fetch_valid, redirect_cnt, align_err
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: holds the architectural PC, fetches through a
// req/ready handshake, presents the instruction to the datapath and commits
// the next PC (Result or PC+4) when the datapath retires it.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : pc_fetch_if.master (PCS, Result, instr_done, imem_ready in;
//                imem_req, PC, PCPlus4, PCPlus8, fetch_valid, redirect_cnt,
//                align_err out)
// Optional feature: define PC_ALIGN_CHECK_EN to get a sticky align_err on
// redirects to a misaligned target; otherwise align_err is tied to 0.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_e;

  state_e           state_q;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q;
  logic             valid_q;
  logic             align_q, align_d;

  // Commit values for a retire edge; only used when in EXEC with instr_done.
  always_comb begin
    pc_d    = bus.PCS ? {bus.Result[31:2], 2'b00} : pc_q + 32'd4;
    cnt_d   = cnt_q;
    align_d = align_q;
    if (bus.PCS) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`ifdef PC_ALIGN_CHECK_EN
      if (bus.Result[1:0] != 2'b00) align_d = 1'b1;
`endif
    end
  end

  // State, PC and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      align_q <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (bus.imem_ready) begin
            state_q <= S_EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (bus.instr_done) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            align_q <= align_d;
          end
        end
        default: begin
          state_q <= S_HOLD;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req     = req_q;
  assign bus.fetch_valid  = valid_q;
  assign bus.PC           = pc_q;
  assign bus.PCPlus4      = pc_q + 32'd4;
  assign bus.PCPlus8      = pc_q + 32'd8;
  assign bus.redirect_cnt = cnt_q;

`ifdef PC_ALIGN_CHECK_EN
  assign bus.align_err = align_q;
`else
  // Target low bits are simply dropped when the check is disabled.
  logic unused_align;
  assign unused_align  = align_q ^ align_d ^ (^bus.Result[1:0]);
  assign bus.align_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  localparam int unsigned CNT_W = 16;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pc_fetch_if #(.CNT_W(CNT_W)) bus ();

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full output check against an expected architectural snapshot.
  task automatic chk_all(input string tag, input logic [31:0] pc, input logic req,
                         input logic vld, input logic [31:0] cnt, input logic aerr);
    chk({tag, ".PC"}, bus.PC, pc);
    chk({tag, ".PCPlus4"}, bus.PCPlus4, pc + 32'd4);
    chk({tag, ".PCPlus8"}, bus.PCPlus8, pc + 32'd8);
    chk({tag, ".imem_req"}, 32'(bus.imem_req), 32'(req));
    chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(vld));
    chk({tag, ".redirect_cnt"}, 32'(bus.redirect_cnt), cnt);
    chk({tag, ".align_err"}, 32'(bus.align_err), 32'(aerr));
  endtask

  typedef struct {
    int          stall;      // cycles of imem_ready=0 in REQ
    logic        pcs;
    logic [31:0] result;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_align;  // value when the alignment check is built in
  } vec_t;

  vec_t vecs[11];

  // Transaction-level reference: after boot, the sequencer is either waiting
  // on memory (requesting) or presenting an instruction until it retires.
  logic        m_booted, m_presented, m_align;
  logic [31:0] m_pc;
  int unsigned m_cnt;

  task automatic model_reset();
    m_booted = 1'b0; m_presented = 1'b0; m_align = 1'b0; m_pc = 32'h0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic pcs, input logic [31:0] res,
                            input logic done, input logic ready);
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (!m_presented) begin
      if (ready) m_presented = 1'b1;
    end else if (done) begin
      if (pcs) begin
        m_pc = res & 32'hFFFF_FFFC;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (ALIGN_EN && (res % 4 != 0)) m_align = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_presented = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] prev_pc;
    checks = 0;
    failures = 0;

    vecs[0]  = '{0, 1'b0, 32'h0000_0000, 32'h0000_0004, 0, 1'b0};
    vecs[1]  = '{0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0008, 0, 1'b0};
    vecs[2]  = '{0, 1'b1, 32'h0000_0100, 32'h0000_0100, 1, 1'b0};
    vecs[3]  = '{2, 1'b0, 32'h0000_0300, 32'h0000_0104, 1, 1'b0};
    vecs[4]  = '{5, 1'b1, 32'h0000_0206, 32'h0000_0204, 2, 1'b1};
    vecs[5]  = '{1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 3, 1'b1};
    vecs[6]  = '{0, 1'b0, 32'h1234_5678, 32'h0000_0000, 3, 1'b1};
    vecs[7]  = '{0, 1'b0, 32'h0, 32'h0000_0004, 3, 1'b1};
    vecs[8]  = '{0, 1'b0, 32'h0, 32'h0000_0008, 3, 1'b1};
    vecs[9]  = '{0, 1'b0, 32'h0, 32'h0000_000C, 3, 1'b1};
    vecs[10] = '{3, 1'b1, 32'h0000_0011, 32'h0000_0010, 4, 1'b1};

    bus.PCS = 1'b0; bus.Result = 32'h0; bus.instr_done = 1'b0; bus.imem_ready = 1'b0;

    // Boot: outputs idle in reset, request appears after the first edge.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    bus.instr_done = 1'b1; bus.PCS = 1'b1; bus.Result = 32'h0000_0400;
    @(posedge clk); #1;
    chk_all("boot", 32'h0, 1'b1, 1'b0, 0, 1'b0);

    // Directed retire table, including stalls with stray retire inputs in REQ.
    prev_pc = 32'h0;
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < vecs[i].stall; k++) begin
        bus.imem_ready = 1'b0; bus.instr_done = 1'b1; bus.PCS = 1'b1; bus.Result = $urandom;
        @(posedge clk); #1;
        chk($sformatf("v%0d.stall%0d.req", i, k), 32'(bus.imem_req), 32'd1);
        chk($sformatf("v%0d.stall%0d.pc", i, k), bus.PC, prev_pc);
      end
      bus.imem_ready = 1'b1; bus.instr_done = 1'b0; bus.PCS = 1'b1; bus.Result = $urandom;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d.exec", i), prev_pc, 1'b0, 1'b1,
              (i == 0) ? 0 : vecs[i-1].exp_cnt, (i == 0) ? 1'b0 : (vecs[i-1].exp_align & ALIGN_EN));
      bus.imem_ready = 1'($urandom); bus.instr_done = 1'b1;
      bus.PCS = vecs[i].pcs; bus.Result = vecs[i].result;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d.retire", i), vecs[i].exp_pc, 1'b1, 1'b0,
              vecs[i].exp_cnt, vecs[i].exp_align & ALIGN_EN);
      bus.instr_done = 1'b0;
      prev_pc = vecs[i].exp_pc;
    end

    // Reset in EXEC with a pending redirect retire: aborts, nothing commits.
    bus.imem_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst.pre.valid", 32'(bus.fetch_valid), 32'd1);
    bus.instr_done = 1'b1; bus.PCS = 1'b1; bus.Result = 32'h0000_0500;
    #1 rst_n = 1'b0;
    #1;
    chk_all("midrst.async", 32'h0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    chk_all("midrst.held", 32'h0, 1'b0, 1'b0, 0, 1'b0);
    bus.instr_done = 1'b0;
    rst_n = 1'b1;

    // Randomized run against the reference model, with occasional resets.
    model_reset();
    bus.imem_ready = 1'b0; bus.instr_done = 1'b0; bus.PCS = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_edge(bus.PCS, bus.Result, bus.instr_done, bus.imem_ready);
      #1;
      chk_all($sformatf("rnd%0d", c), m_pc, m_booted & ~m_presented, m_presented,
              m_cnt, m_align);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      bus.instr_done = ($urandom_range(0, 2) != 0);
      bus.PCS        = ($urandom_range(0, 3) == 0);
      bus.Result     = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all($sformatf("rnd%0d.rst", c), m_pc, 1'b0, 1'b0, 0, 1'b0);
        #1 rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
